i2c_slave_rx: RTL and testbench

Write-only I2C slave receiver; the consumer directly downstream of the I2C master on the shared SCL/SDA wires. It oversamples SCL/SDA with the system clock and detects START, repeated START and STOP. It matches a 7-bit address, ACKs by pulling SDA low through an open-drain enable, and delivers each received data byte to local logic with a one-cycle valid pulse plus a ready-based accept/NACK handshake.

---
 rtl/i2c_slave_rx.sv | 190 +++++++++++++++++++
 tb/tb_i2c_slave_rx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_rx.sv
// Write-only I2C slave receiver: synchronizes SCL/SDA, decodes START/STOP, matches an address
// and hands received bytes to local logic. Optional line filter: I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave_rx #(
  parameter logic [6:0] SLAVE_ADDR = 7'h5A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda_in,
  input  logic       rx_ready,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ovf,
  output logic       addr_match,
  output logic       busy,
  output logic       stop_det
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StAddr     = 3'd1;
  localparam logic [2:0] StAddrAck  = 3'd2;
  localparam logic [2:0] StData     = 3'd3;
  localparam logic [2:0] StDataAck  = 3'd4;
  localparam logic [2:0] StDataNack = 3'd5;
  localparam logic [2:0] StIgnore   = 3'd6;

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_q, sda_q;  // previous line values, for edge detection
  logic       scl_f, sda_f;

  // Idle bus is high, so resetting to 1 avoids spurious edges on release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl};
      sda_sync_q <= {sda_sync_q[0], sda_in};
      scl_q      <= scl_f;
      sda_q      <= sda_f;
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q, sda_hist_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
    end
  end

  // A line only moves once three consecutive synced samples agree
  assign scl_f = (scl_sync_q[1] == scl_hist_q[0] && scl_sync_q[1] == scl_hist_q[1]) ?
                 scl_sync_q[1] : scl_q;
  assign sda_f = (sda_sync_q[1] == sda_hist_q[0] && sda_sync_q[1] == sda_hist_q[1]) ?
                 sda_sync_q[1] : sda_q;
`else
  assign scl_f = scl_sync_q[1];
  assign sda_f = sda_sync_q[1];
`endif

  logic scl_rise, scl_fall, start_evt, stop_evt;
  assign scl_rise  = scl_f & ~scl_q;
  assign scl_fall  = ~scl_f & scl_q;
  assign start_evt = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_evt  = scl_f & scl_q & ~sda_q & sda_f;

  logic [2:0] state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, rx_data_q, rx_data_d, byte_next;
  logic       sda_oe_q, sda_oe_d, rx_valid_q, rx_valid_d, rx_ovf_q, rx_ovf_d;
  logic       addr_match_q, addr_match_d, busy_q, busy_d, stop_det_q, stop_det_d;
  logic       acc_q, acc_d;

  assign byte_next = {shift_q[6:0], sda_f};

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    sda_oe_d     = sda_oe_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    rx_ovf_d     = 1'b0;
    addr_match_d = addr_match_q;
    busy_d       = busy_q;
    stop_det_d   = 1'b0;
    acc_d        = acc_q;
    if (stop_evt) begin
      state_d      = StIdle;
      bit_cnt_d    = 4'd0;
      sda_oe_d     = 1'b0;
      addr_match_d = 1'b0;
      busy_d       = 1'b0;
      stop_det_d   = 1'b1;
    end else if (start_evt) begin
      state_d      = StAddr;
      bit_cnt_d    = 4'd0;
      sda_oe_d     = 1'b0;
      addr_match_d = 1'b0;
      busy_d       = 1'b1;
    end else begin
      if (scl_rise && bit_cnt_q < 4'd8 && (state_q == StAddr || state_q == StData)) begin
        shift_d   = byte_next;
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
      case (state_q)
        StAddr: begin
          if (scl_fall && bit_cnt_q == 4'd8) begin
            if (shift_q[7:1] == SLAVE_ADDR && !shift_q[0]) begin
              state_d      = StAddrAck;
              sda_oe_d     = 1'b1;
              addr_match_d = 1'b1;
            end else begin
              state_d = StIgnore;
            end
          end
        end
        StData: begin
          if (scl_rise && bit_cnt_q == 4'd7) begin
            acc_d = rx_ready;
            if (rx_ready) begin
              rx_data_d  = byte_next;
              rx_valid_d = 1'b1;
            end else begin
              rx_ovf_d = 1'b1;
            end
          end
          if (scl_fall && bit_cnt_q == 4'd8) begin
            state_d  = acc_q ? StDataAck : StDataNack;
            sda_oe_d = acc_q;
          end
        end
        StAddrAck, StDataAck, StDataNack: begin
          if (scl_fall) begin
            state_d   = StData;
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      bit_cnt_q    <= 4'd0;
      shift_q      <= 8'h00;
      sda_oe_q     <= 1'b0;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      rx_ovf_q     <= 1'b0;
      addr_match_q <= 1'b0;
      busy_q       <= 1'b0;
      stop_det_q   <= 1'b0;
      acc_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      sda_oe_q     <= sda_oe_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_ovf_q     <= rx_ovf_d;
      addr_match_q <= addr_match_d;
      busy_q       <= busy_d;
      stop_det_q   <= stop_det_d;
      acc_q        <= acc_d;
    end
  end

  assign sda_oe     = sda_oe_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_ovf     = rx_ovf_q;
  assign addr_match = addr_match_q;
  assign busy       = busy_q;
  assign stop_det   = stop_det_q;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Bench for i2c_slave_rx: bit-banged I2C master, transaction-level model feeding an event
// scoreboard, and a monitor that pops and compares on every DUT output event.
`timescale 1ns/1ps
module tb_i2c_slave_rx;

  localparam int Q = 80;  // quarter SCL period in ns (SCL period = 32 clk)
  localparam logic [6:0] Addr = 7'h5A;
  localparam int EvValid = 1, EvOvf = 2, EvAck = 3, EvStop = 4;

  logic clk = 1'b0;
  logic rst, scl, sda_m, rx_ready;
  logic sda_oe, rx_valid, rx_ovf, addr_match, busy, stop_det;
  logic [7:0] rx_data;
  wire  sda_w = sda_m & ~sda_oe;  // open-drain wired-AND bus

  always #5 clk = ~clk;

  i2c_slave_rx #(.SLAVE_ADDR(Addr)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda_in(sda_w), .rx_ready(rx_ready),
    .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ovf(rx_ovf),
    .addr_match(addr_match), .busy(busy), .stop_det(stop_det)
  );

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  logic [7:0] exp_last = 8'h00;
  logic [7:0] tx_data[4];
  logic       tx_rdy[4];
  logic       oe_prev = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input logic [7:0] d);
    exp_q.push_back(kind * 256 + int'(d));
  endtask

  task automatic pop_cmp(input string name, input int got);
    int e;
    e = (exp_q.size() == 0) ? -1 : exp_q.pop_front();
    chk(name, got, e);
  endtask

  // Monitor: every output event must match the head of the expected queue
  always @(negedge clk) begin
    if (rst) begin
      if (rx_valid)            pop_cmp("rx_valid_event", EvValid * 256 + int'(rx_data));
      if (rx_ovf)              pop_cmp("rx_ovf_event", EvOvf * 256);
      if (stop_det)            pop_cmp("stop_det_event", EvStop * 256);
      if (sda_oe && !oe_prev)  pop_cmp("ack_event", EvAck * 256);
    end
    oe_prev <= sda_oe;
  end

  task automatic start_c();
    sda_m = 1'b1; scl = 1'b1; #Q; sda_m = 1'b0; #Q; scl = 1'b0; #Q;
  endtask

  task automatic rstart_c();
    sda_m = 1'b1; #Q; scl = 1'b1; #Q; sda_m = 1'b0; #Q; scl = 1'b0; #Q;
  endtask

  task automatic stop_c();
    sda_m = 1'b0; #Q; scl = 1'b1; #Q; sda_m = 1'b1; #Q;
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; #Q; scl = 1'b1; #(2 * Q); scl = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  // One write/read frame; the model predicts the event stream from the bus-level rules
  task automatic xfer(input logic [6:0] a, input logic rw, input int n, input bit rep,
                      input bit do_stop);
    bit match;
    match = (a == Addr) && !rw;
    if (match) push_ev(EvAck, 8'h00);
    for (int i = 0; i < n; i++) begin
      if (!match) continue;
      if (tx_rdy[i]) begin
        push_ev(EvValid, tx_data[i]);
        push_ev(EvAck, 8'h00);
        exp_last = tx_data[i];
      end else begin
        push_ev(EvOvf, 8'h00);
      end
    end
    if (do_stop) push_ev(EvStop, 8'h00);

    if (rep) rstart_c(); else start_c();
    chk("busy_after_start", int'(busy), 1);
    send_byte({a, rw});
    send_bit(1'b1);
    chk("addr_match_level", int'(addr_match), int'(match));
    for (int i = 0; i < n; i++) begin
      rx_ready = tx_rdy[i];
      send_byte(tx_data[i]);
      send_bit(1'b1);
    end
    rx_ready = 1'b1;
    chk("rx_data_hold", int'(rx_data), int'(exp_last));
    if (do_stop) begin
      stop_c();
      chk("busy_after_stop", int'(busy), 0);
      chk("addr_match_after_stop", int'(addr_match), 0);
    end
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: time limit reached, pending=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    bit glitch_counts, prev_stop;
    logic [7:0] gd;
    logic g;
    logic stream[$];
    logic [7:0] exp_b;

    rst = 1'b0; scl = 1'b1; sda_m = 1'b1; rx_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("reset_sda_oe", int'(sda_oe), 0);
    chk("reset_rx_data", int'(rx_data), 0);
    chk("reset_rx_valid", int'(rx_valid), 0);
    chk("reset_rx_ovf", int'(rx_ovf), 0);
    chk("reset_addr_match", int'(addr_match), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_stop_det", int'(stop_det), 0);
    #3 rst = 1'b1;
    repeat (4) @(posedge clk);

    // Baseline write
    tx_data[0] = 8'hA5; tx_rdy[0] = 1'b1; tx_data[1] = 8'h3C; tx_rdy[1] = 1'b1;
    xfer(7'h5A, 1'b0, 2, 1'b0, 1'b1);
    // Address mismatch
    tx_data[0] = 8'hC3; tx_rdy[0] = 1'b1;
    xfer(7'h5B, 1'b0, 1, 1'b0, 1'b1);
    // Read request
    xfer(7'h5A, 1'b1, 0, 1'b0, 1'b1);
    // Backpressure on the second byte
    tx_data[0] = 8'h42; tx_rdy[0] = 1'b1; tx_data[1] = 8'h77; tx_rdy[1] = 1'b0;
    xfer(7'h5A, 1'b0, 2, 1'b0, 1'b1);
    // Repeated START framing, then STOP mid-byte
    tx_data[0] = 8'h99; tx_rdy[0] = 1'b1;
    xfer(7'h5A, 1'b0, 1, 1'b0, 1'b0);
    tx_data[0] = 8'h11; tx_rdy[0] = 1'b1;
    xfer(7'h5A, 1'b0, 1, 1'b1, 1'b0);
    push_ev(EvStop, 8'h00);
    for (int i = 0; i < 4; i++) send_bit(1'(i));
    stop_c();
    chk("busy_after_partial", int'(busy), 0);

    // Short SCL pulse mid-byte: a bit only when the filter is absent
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    glitch_counts = 1'b0;
`else
    glitch_counts = 1'b1;
`endif
    gd = 8'($urandom); g = 1'($urandom);
    xfer(7'h5A, 1'b0, 0, 1'b0, 1'b0);
    stream.delete();
    for (int i = 7; i >= 5; i--) stream.push_back(gd[i]);
    if (glitch_counts) stream.push_back(g);
    for (int i = 4; i >= 1; i--) stream.push_back(gd[i]);
    stream.push_back(1'b1);
    exp_b = 8'h00;
    for (int i = 0; i < 8; i++) exp_b = {exp_b[6:0], stream[i]};
    push_ev(EvValid, exp_b); push_ev(EvAck, 8'h00); push_ev(EvStop, 8'h00);
    exp_last = exp_b;
    rx_ready = 1'b1;
    for (int i = 7; i >= 5; i--) send_bit(gd[i]);
    sda_m = g; #Q; scl = 1'b1; #20; scl = 1'b0; #Q;
    for (int i = 4; i >= 1; i--) send_bit(gd[i]);
    send_bit(1'b1);
    send_bit(1'b1);
    stop_c();
    chk("glitch_rx_data", int'(rx_data), int'(exp_b));

    // Asynchronous reset while ACKing
    push_ev(EvAck, 8'h00);
    start_c();
    send_byte({Addr, 1'b0});
    sda_m = 1'b1; #Q; scl = 1'b1; #Q;
    chk("ack_before_reset", int'(sda_oe), 1);
    @(posedge clk); #2; rst = 1'b0; #1;
    chk("reset_drops_sda_oe", int'(sda_oe), 0);
    chk("reset_drops_addr_match", int'(addr_match), 0);
    exp_last = 8'h00;
    #33 rst = 1'b1;
    #Q; scl = 1'b0; #Q;
    push_ev(EvStop, 8'h00);
    stop_c();

    // Randomized frames
    prev_stop = 1'b1;
    for (int t = 0; t < 20; t++) begin
      logic [6:0] a;
      logic rw;
      int n, sel;
      bit st;
      sel = int'($urandom_range(0, 3));
      a = (sel < 2) ? Addr : (sel == 2) ? 7'h5B : 7'($urandom);
      rw = ($urandom_range(0, 4) == 0);
      n = int'($urandom_range(0, 3));
      for (int i = 0; i < 4; i++) begin
        tx_data[i] = 8'($urandom);
        tx_rdy[i] = ($urandom_range(0, 3) != 0);
      end
      st = ($urandom_range(0, 4) != 0);
      xfer(a, rw, n, !prev_stop, st);
      prev_stop = st;
    end
    if (!prev_stop) begin
      push_ev(EvStop, 8'h00);
      stop_c();
    end

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
